fir_mac_out: RTL and testbench

FIR_MAC_OUT -- requirements
Module: fir_mac_out

---
 rtl/fir_pkg.sv | 26 ++
 rtl/fir_mac_out_if.sv | 32 +++
 rtl/fir_out_fifo.sv | 79 +++++++
 rtl/fir_mac_out.sv | 144 ++++++++++++++
 tb/tb_fir_mac_out.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// ---------------------------------------------------------------------------
// fir_pkg
// Shared definitions for the FIR output path and its address generator:
//   pDATA_WIDTH  - default data / tap / accumulator width
//   pFIFO_DEPTH  - default output FIFO depth (power of two, >= 2)
//   fir_state_e  - output sequencer state encoding
//   eff_length() - sequence length with zero mapped to one sample
// ---------------------------------------------------------------------------
package fir_pkg;

    localparam int pDATA_WIDTH = 32;
    localparam int pFIFO_DEPTH = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACC   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_PUSH  = 2'd3
    } fir_state_e;

    // A zero-length request still produces one sample.
    function automatic logic [31:0] eff_length(input logic [31:0] len);
        return (len == 32'd0) ? 32'd1 : len;
    endfunction

endpackage

// File: rtl/fir_mac_out_if.sv
// ---------------------------------------------------------------------------
// fir_mac_out_if
// AXI-Stream output channel of the FIR engine.
//   sm_tvalid / sm_tready - handshake
//   sm_tdata              - output sample
//   sm_tlast              - final sample of the sequence
// master: the FIR engine; slave: the downstream consumer.
// ---------------------------------------------------------------------------
interface fir_mac_out_if #(
    parameter int pDATA_WIDTH = fir_pkg::pDATA_WIDTH
) ();

    logic                   sm_tvalid;
    logic                   sm_tready;
    logic [pDATA_WIDTH-1:0] sm_tdata;
    logic                   sm_tlast;

    modport master (
        output sm_tvalid,
        output sm_tdata,
        output sm_tlast,
        input  sm_tready
    );

    modport slave (
        input  sm_tvalid,
        input  sm_tdata,
        input  sm_tlast,
        output sm_tready
    );

endinterface

// File: rtl/fir_out_fifo.sv
// ---------------------------------------------------------------------------
// fir_out_fifo
// Small synchronous FIFO holding {last, data} output beats.
//   clk, rst_n - clock, asynchronous active-low reset
//   wr_en      - write request (ignored when full unless a read happens too)
//   wr_data    - beat to store
//   rd_en      - read request (ignored when empty)
//   rd_data    - head beat, forced to zero while empty
//   empty      - no beats stored
//   full       - registered, count == pDEPTH
// ---------------------------------------------------------------------------
module fir_out_fifo #(
    parameter int pWIDTH = 33,
    parameter int pDEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [pWIDTH-1:0] wr_data,
    input  logic              rd_en,
    output logic [pWIDTH-1:0] rd_data,
    output logic              empty,
    output logic              full
);

    localparam int PW = $clog2(pDEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(pDEPTH);

    logic [pWIDTH-1:0] mem_q [pDEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              full_q, full_d;
    logic              do_wr, do_rd;

    // A write into a full FIFO is accepted when the head leaves in the same
    // cycle; the freed slot is the one being written.
    assign do_rd = rd_en && (count_q != '0);
    assign do_wr = wr_en && (!full_q || do_rd);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_rd) rd_ptr_d = rd_ptr_q + PW'(1);
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        full_d = (count_d == FULL_CNT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
        end
    end

    // Storage needs no reset; the read port is masked while empty.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data;
    end

    assign empty   = (count_q == '0);
    assign full    = full_q;
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/fir_mac_out.sv
// ---------------------------------------------------------------------------
// fir_mac_out
// FIR multiply-accumulate back end: a two-stage MAC, a sequencer that
// pushes each finished tap sum into an output FIFO, and an AXI-Stream master.
//   axis_clk, axis_rst_n - clock, asynchronous active-low reset
//   ap_start, data_length - start/restart a sequence of data_length samples
//   mac_reset            - clear the accumulator
//   mac_EN, tap_Do, data_Do - multiply-accumulate strobe and operands
//   result_ready         - current tap sum is complete
//   sm                   - AXI-Stream output (master modport)
//   out_full             - output FIFO full, upstream holds off
//   ovf_err              - sticky, a sample was dropped
//   done                 - pulse after the last beat handshakes
// ---------------------------------------------------------------------------
module fir_mac_out #(
    parameter int pDATA_WIDTH = fir_pkg::pDATA_WIDTH,
    parameter int pFIFO_DEPTH = fir_pkg::pFIFO_DEPTH
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   ap_start,
    input  logic [31:0]            data_length,
    input  logic                   mac_reset,
    input  logic                   mac_EN,
    input  logic                   result_ready,
    input  logic [pDATA_WIDTH-1:0] tap_Do,
    input  logic [pDATA_WIDTH-1:0] data_Do,
    fir_mac_out_if.master          sm,
    output logic                   out_full,
    output logic                   ovf_err,
    output logic                   done
);

    import fir_pkg::*;

    fir_state_e             state_q;
    logic [31:0]            len_q;
    logic [31:0]            sample_cnt_q;
    logic                   ovf_err_q;
    logic                   done_q;

    logic [pDATA_WIDTH-1:0] prod_q, prod_d;
    logic                   prod_v_q, prod_v_d;
    logic [pDATA_WIDTH-1:0] acc_q, acc_d;
    logic signed [pDATA_WIDTH-1:0] product;

    logic                   push;
    logic                   push_last;
    logic                   fifo_rd;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic [pDATA_WIDTH:0]   fifo_rd_data;

    // Truncating the signed product to pDATA_WIDTH keeps exactly its low bits.
    assign product = $signed(tap_Do) * $signed(data_Do);

    // Two-stage MAC: register the product, then fold it into the accumulator.
    // mac_reset wins over both stages so a new sample starts from zero.
    always_comb begin
        prod_d   = prod_q;
        prod_v_d = 1'b0;
        acc_d    = acc_q;
        if (mac_EN) begin
            prod_d   = product;
            prod_v_d = 1'b1;
        end
        if (prod_v_q) acc_d = acc_q + prod_q;
        if (mac_reset) begin
            acc_d    = '0;
            prod_v_d = 1'b0;
        end
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            prod_q   <= '0;
            prod_v_q <= 1'b0;
            acc_q    <= '0;
        end else begin
            prod_q   <= prod_d;
            prod_v_q <= prod_v_d;
            acc_q    <= acc_d;
        end
    end

    assign push      = (state_q == ST_PUSH);
    assign push_last = (sample_cnt_q == len_q - 32'd1);
    assign fifo_rd   = sm.sm_tvalid && sm.sm_tready;

    // Sequencer: ACC collects products until result_ready, DRAIN lets the
    // product still in flight land in acc, PUSH hands the sum to the FIFO.
    // ap_start restarts from any state but leaves queued beats alone.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state_q      <= ST_IDLE;
            len_q        <= 32'd1;
            sample_cnt_q <= '0;
            ovf_err_q    <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= fifo_rd && sm.sm_tlast;
            if (ap_start) begin
                len_q        <= eff_length(data_length);
                sample_cnt_q <= '0;
                ovf_err_q    <= 1'b0;
                state_q      <= ST_ACC;
            end else begin
                case (state_q)
                    ST_IDLE:  state_q <= ST_IDLE;
                    ST_ACC:   if (result_ready) state_q <= ST_DRAIN;
                    ST_DRAIN: if (!prod_v_q) state_q <= ST_PUSH;
                    ST_PUSH: begin
                        sample_cnt_q <= sample_cnt_q + 32'd1;
                        if (fifo_full && !fifo_rd) ovf_err_q <= 1'b1;
                        state_q <= push_last ? ST_IDLE : ST_ACC;
                    end
                    default:  state_q <= ST_IDLE;
                endcase
            end
        end
    end

    fir_out_fifo #(
        .pWIDTH (pDATA_WIDTH + 1),
        .pDEPTH (pFIFO_DEPTH)
    ) u_fifo (
        .clk     (axis_clk),
        .rst_n   (axis_rst_n),
        .wr_en   (push),
        .wr_data ({push_last, acc_q}),
        .rd_en   (fifo_rd),
        .rd_data (fifo_rd_data),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    assign sm.sm_tvalid = !fifo_empty;
    assign sm.sm_tdata  = fifo_rd_data[pDATA_WIDTH-1:0];
    assign sm.sm_tlast  = fifo_rd_data[pDATA_WIDTH];
    assign out_full     = fifo_full;
    assign ovf_err      = ovf_err_q;
    assign done         = done_q;

endmodule

// File: tb/tb_fir_mac_out.sv
// ---------------------------------------------------------------------------
// tb_fir_mac_out
// Directed bench for fir_mac_out with hand-computed expected samples.
// ---------------------------------------------------------------------------
module tb_fir_mac_out;

    logic        clk;
    logic        rstN;
    logic        apStart;
    logic [31:0] dataLength;
    logic        macReset;
    logic        macEn;
    logic        resultReady;
    logic [31:0] tapDo;
    logic [31:0] dataDo;
    logic        outFull;
    logic        ovfErr;
    logic        done;

    int compareCount  = 0;
    int mismatchCount = 0;

    fir_mac_out_if #(.pDATA_WIDTH(32)) sm ();

    fir_mac_out #(
        .pDATA_WIDTH (32),
        .pFIFO_DEPTH (2)
    ) dut (
        .axis_clk     (clk),
        .axis_rst_n   (rstN),
        .ap_start     (apStart),
        .data_length  (dataLength),
        .mac_reset    (macReset),
        .mac_EN       (macEn),
        .result_ready (resultReady),
        .tap_Do       (tapDo),
        .data_Do      (dataDo),
        .sm           (sm),
        .out_full     (outFull),
        .ovf_err      (ovfErr),
        .done         (done)
    );

    // 100 MHz free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one cycle and land 1 ns after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count a comparison and report it when observed differs from expected
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of control/data inputs, then let the edge happen
    task automatic applyStimulus(input logic ap, input logic [31:0] len,
                                 input logic mrst, input logic men,
                                 input logic [31:0] tap, input logic [31:0] dat,
                                 input logic rr);
        apStart     = ap;
        dataLength  = len;
        macReset    = mrst;
        macEn       = men;
        tapDo       = tap;
        dataDo      = dat;
        resultReady = rr;
        tick();
        apStart     = 1'b0;
        macReset    = 1'b0;
        macEn       = 1'b0;
        resultReady = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0);
    endtask

    // Bounded wait for a beat; an expired bound shows up as a failed check
    task automatic waitValid(input string tag);
        int n = 0;
        while (!sm.sm_tvalid && n < 20) begin
            tick();
            n++;
        end
        checkOutput({tag, "_valid"}, 64'(sm.sm_tvalid), 64'd1);
    endtask

    // Wait for a beat with sm_tready=1, check it, then check the done pulse
    task automatic expectBeat(input string tag, input logic [31:0] expData,
                              input logic expLast);
        waitValid(tag);
        checkOutput({tag, "_data"}, 64'(sm.sm_tdata), 64'(expData));
        checkOutput({tag, "_last"}, 64'(sm.sm_tlast), 64'(expLast));
        tick();
        checkOutput({tag, "_done1"}, 64'(done), 64'(expLast));
        tick();
        checkOutput({tag, "_done2"}, 64'(done), 64'd0);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_tvalid"}, 64'(sm.sm_tvalid), 64'd0);
        checkOutput({tag, "_tdata"},  64'(sm.sm_tdata),  64'd0);
        checkOutput({tag, "_tlast"},  64'(sm.sm_tlast),  64'd0);
        checkOutput({tag, "_full"},   64'(outFull),      64'd0);
        checkOutput({tag, "_ovf"},    64'(ovfErr),       64'd0);
        checkOutput({tag, "_done"},   64'(done),         64'd0);
    endtask

    initial begin
        rstN         = 1'b0;
        apStart      = 1'b0;
        dataLength   = 32'd0;
        macReset     = 1'b0;
        macEn        = 1'b0;
        resultReady  = 1'b0;
        tapDo        = 32'd0;
        dataDo       = 32'd0;
        sm.sm_tready = 1'b1;
        tick();
        tick();
        checkResetOutputs("reset");
        rstN = 1'b1;
        tick();

        // 11 unit taps over data 1..11 -> 66, single last sample
        $display("[TB] eleven-tap sum");
        applyStimulus(1, 1, 1, 0, 0, 0, 0);
        for (int i = 1; i <= 11; i++) applyStimulus(0, 0, 0, 1, 1, i, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        expectBeat("sum66", 32'd66, 1'b1);

        // result_ready with the sequencer idle produces nothing
        $display("[TB] result_ready in idle");
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        idle(5);
        checkOutput("idle_rr_valid", 64'(sm.sm_tvalid), 64'd0);

        // -2 * 3 = -6, plus the 3-cycle result_ready -> tvalid latency
        $display("[TB] signed product and latency");
        applyStimulus(1, 1, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 32'hFFFF_FFFE, 32'd3, 0);
        idle(1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("lat_c1", 64'(sm.sm_tvalid), 64'd0);
        idle(1);
        checkOutput("lat_c2", 64'(sm.sm_tvalid), 64'd0);
        idle(1);
        checkOutput("lat_c3", 64'(sm.sm_tvalid), 64'd1);
        expectBeat("neg6", 32'hFFFF_FFFA, 1'b1);

        // 0x7FFFFFFF twice wraps to 0xFFFFFFFE without an error flag
        $display("[TB] accumulator wrap");
        applyStimulus(1, 1, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 32'h7FFF_FFFF, 32'd1, 0);
        applyStimulus(0, 0, 0, 1, 32'h7FFF_FFFF, 32'd1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        waitValid("wrap");
        checkOutput("wrap_ovf", 64'(ovfErr), 64'd0);
        expectBeat("wrap", 32'hFFFF_FFFE, 1'b1);

        // Product strobed with result_ready is included; length 0 acts as 1
        $display("[TB] same-cycle product, zero length");
        applyStimulus(1, 0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 32'd5, 32'd7, 0);
        applyStimulus(0, 0, 0, 1, 32'd3, 32'd4, 1);
        expectBeat("samecyc", 32'd47, 1'b1);

        // Back-pressure: two samples fill the FIFO, the third is dropped
        $display("[TB] overflow under back-pressure");
        sm.sm_tready = 1'b0;
        applyStimulus(1, 3, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(0, 0, 1, 0, 0, 0, 0);
            applyStimulus(0, 0, 0, 1, k, 32'd10, 0);
            applyStimulus(0, 0, 0, 0, 0, 0, 1);
            idle(3);
            if (k == 1) begin
                checkOutput("bp1_full", 64'(outFull), 64'd0);
                checkOutput("bp1_data", 64'(sm.sm_tdata), 64'd10);
            end
            if (k == 2) begin
                checkOutput("bp2_full", 64'(outFull), 64'd1);
                checkOutput("bp2_ovf",  64'(ovfErr), 64'd0);
                checkOutput("bp2_hold", 64'(sm.sm_tdata), 64'd10);
            end
        end
        checkOutput("bp3_ovf",  64'(ovfErr), 64'd1);
        checkOutput("bp3_full", 64'(outFull), 64'd1);
        sm.sm_tready = 1'b1;
        checkOutput("rd1_data", 64'(sm.sm_tdata), 64'd10);
        checkOutput("rd1_last", 64'(sm.sm_tlast), 64'd0);
        tick();
        checkOutput("rd2_data", 64'(sm.sm_tdata), 64'd20);
        checkOutput("rd2_last", 64'(sm.sm_tlast), 64'd0);
        checkOutput("rd2_full", 64'(outFull), 64'd0);
        tick();
        checkOutput("rd_empty", 64'(sm.sm_tvalid), 64'd0);
        checkOutput("rd_done",  64'(done), 64'd0);
        checkOutput("ovf_sticky", 64'(ovfErr), 64'd1);
        applyStimulus(1, 1, 1, 0, 0, 0, 0);
        checkOutput("ovf_clear", 64'(ovfErr), 64'd0);

        // Asynchronous reset in DRAIN with a beat still queued
        $display("[TB] reset during drain");
        sm.sm_tready = 1'b0;
        applyStimulus(1, 2, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 32'd9, 32'd1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        idle(3);
        checkOutput("pre_rst_valid", 64'(sm.sm_tvalid), 64'd1);
        checkOutput("pre_rst_data",  64'(sm.sm_tdata),  64'd9);
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 32'd2, 32'd2, 1);
        #2;
        rstN = 1'b0;
        #1;
        checkResetOutputs("async_rst");
        tick();
        tick();
        rstN = 1'b1;
        sm.sm_tready = 1'b1;
        tick();
        applyStimulus(1, 1, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 32'd6, 32'd7, 0);
        idle(1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        expectBeat("post_rst", 32'd42, 1'b1);
        checkOutput("post_rst_empty", 64'(sm.sm_tvalid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
